// File: rtl/fifo_top_sync.sv
// Single-clock synchronous FIFO with registered read data and count-decoded status.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_top_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO can still take a push when the same cycle frees a slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge wr_clk) begin
    if (!wr_rst && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky until reset so software can find a past violation.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_top_sync.sv
// Self-checking bench for fifo_top_sync: vector table plus queue-model scoreboard.
module tb_fifo_top_sync;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo_top_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    bit       push;
    bit [7:0] data;
    bit       pop;
    int       exp_count;
    bit       exp_full;
    bit       exp_empty;
    bit [7:0] exp_pop_data;
  } vec_t;

  vec_t     vecs[8];
  bit [7:0] model_q[$];
  bit [7:0] score_q[$];
  bit [7:0] exp_hold;
  bit       exp_ovf;
  bit       exp_unf;
  int       checks = 0;
  int       passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (score_q.size() > 0) begin
      exp_hold = score_q.pop_front();
    end
    check("count", int'(count), model_q.size());
    check("full", int'(full), int'(model_q.size() == DEPTH));
    check("empty", int'(empty), int'(model_q.size() == 0));
    check("pop_data", int'(pop_data), int'(exp_hold));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", int'(overflow), int'(exp_ovf));
    check("underflow", int'(underflow), int'(exp_unf));
`endif
  endtask

  // One clock of stimulus: the queue model decides acceptance, then outputs are checked.
  task automatic applyStimulus(input bit rst, input bit p, input bit [7:0] d, input bit q);
    bit pop_acc;
    bit push_acc;
    wr_rst    = rst;
    push      = p;
    push_data = d;
    pop       = q;
    if (rst) begin
      model_q.delete();
      score_q.delete();
      exp_hold = 8'h00;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      pop_acc  = q && (model_q.size() > 0);
      push_acc = p && ((model_q.size() < DEPTH) || pop_acc);
      if (p && !push_acc) exp_ovf = 1'b1;
      if (q && !pop_acc)  exp_unf = 1'b1;
      if (pop_acc)  score_q.push_back(model_q.pop_front());
      if (push_acc) model_q.push_back(d);
    end
    @(posedge wr_clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // push, data, pop, count, full, empty, pop_data (hand-derived from reset)
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 2, 1'b0, 1'b0, 8'h11};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h22};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h33};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h33};
    vecs[6] = '{1'b1, 8'h77, 1'b1, 1, 1'b0, 1'b0, 8'h33};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h77};

    exp_hold = 8'h00;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;

    // Reset held two cycles
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].push, vecs[i].data, vecs[i].pop);
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
      check($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d_pop_data", i), int'(pop_data), int'(vecs[i].exp_pop_data));
    end

    // Fill past full, then drain past empty
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 15) check("full_after_16", int'(full), 1);
    end
    check("count_capped", int'(count), DEPTH);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("drain_hold_15", int'(pop_data), 15);

    // Wrap-around
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(i + 8'h40), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      check("wrap_data", int'(pop_data), 8'hA0 + i);
    end
    check("wrap_count", int'(count), 0);

    // Simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
    check("full_pp_data", int'(pop_data), 8'hC0);
    check("full_pp_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check("full_pp_last", int'(pop_data), 8'h55);

    // Simultaneous push and pop while empty
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1);
    check("empty_pp_count", int'(count), 1);
    check("empty_pp_hold", int'(pop_data), 8'h55);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check("empty_pp_next", int'(pop_data), 8'h77);

    // Reset mid-operation wins over a push
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
    check("midrst_count", int'(count), 0);
    check("midrst_empty", int'(empty), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check("midrst_pop_ignored", int'(pop_data), 0);
    check("midrst_still_empty", int'(count), 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
